// File: rtl/iter_comparator_if.sv
// Request/result bundle for the slice-serial magnitude comparator.
interface iter_comparator_if #(
  parameter int WIDTH = 32,
  parameter int SLICE = 2
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE) + 1;

  logic             i_start;
  logic             i_signed;
  logic [WIDTH-1:0] i_rs1;
  logic [WIDTH-1:0] i_rs2;
  logic             i_abort;
  logic             o_ready;
  logic             o_valid;
  logic             o_lt;
  logic             o_eq;
  logic             o_gt;
  logic [CW-1:0]    o_slices;

  modport master (
    output i_start, i_signed, i_rs1, i_rs2, i_abort,
    input  o_ready, o_valid, o_lt, o_eq, o_gt, o_slices
  );

  modport slave (
    input  i_start, i_signed, i_rs1, i_rs2, i_abort,
    output o_ready, o_valid, o_lt, o_eq, o_gt, o_slices
  );
endinterface

// File: rtl/iter_comparator.sv
// Slice-serial magnitude comparator: walks operands MSB slice first and stops
// at the first differing slice; signed mode is folded into unsigned by flipping the sign bits.
module iter_comparator #(
  parameter int WIDTH = 32,
  parameter int SLICE = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  iter_comparator_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE) + 1;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1'b1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx_r;
  logic [CW-1:0]    cnt_r;
  logic             ready_r;
  logic             valid_r;
  logic             lt_r;
  logic             eq_r;
  logic             gt_r;
  logic [CW-1:0]    slices_r;

  logic [31:0]      shamt_s;
  logic [WIDTH-1:0] a_sh_s;
  logic [WIDTH-1:0] b_sh_s;
  logic [SLICE-1:0] a_slice_s;
  logic [SLICE-1:0] b_slice_s;

  // Extract the slice currently addressed by idx_r from both operands
  always_comb begin
    shamt_s   = 32'(idx_r) * 32'(SLICE);
    a_sh_s    = a_r >> shamt_s;
    b_sh_s    = b_r >> shamt_s;
    a_slice_s = a_sh_s[SLICE-1:0];
    b_slice_s = b_sh_s[SLICE-1:0];
  end

  // Control FSM with all outputs registered; abort takes priority over a decision
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      idx_r    <= '0;
      cnt_r    <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      lt_r     <= 1'b0;
      eq_r     <= 1'b0;
      gt_r     <= 1'b0;
      slices_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.i_start) begin
            a_r     <= bus.i_signed ? (bus.i_rs1 ^ SIGN_MASK) : bus.i_rs1;
            b_r     <= bus.i_signed ? (bus.i_rs2 ^ SIGN_MASK) : bus.i_rs2;
            idx_r   <= IW'(NSLICE - 1);
            cnt_r   <= '0;
            ready_r <= 1'b0;
            state_r <= RUN;
          end else begin
            ready_r <= 1'b1;
          end
        end
        RUN: begin
          if (bus.i_abort) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else if ((a_slice_s != b_slice_s) || (idx_r == '0)) begin
            lt_r     <= (a_slice_s < b_slice_s);
            eq_r     <= (a_slice_s == b_slice_s);
            gt_r     <= (a_slice_s > b_slice_s);
            slices_r <= cnt_r + CW'(1'b1);
            valid_r  <= 1'b1;
            state_r  <= DONE;
          end else begin
            idx_r <= idx_r - IW'(1'b1);
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready  = ready_r;
  assign bus.o_valid  = valid_r;
  assign bus.o_lt     = lt_r;
  assign bus.o_eq     = eq_r;
  assign bus.o_gt     = gt_r;
  assign bus.o_slices = slices_r;
endmodule

// File: tb/tb_iter_comparator.sv
// Randomised scoreboard bench for iter_comparator at 32/2 and 8/4; the reference
// model uses integer arithmetic for the flags and the first differing bit for the slice count.
module tb_iter_comparator;
  localparam int W_A = 32;
  localparam int S_A = 2;
  localparam int W_B = 8;
  localparam int S_B = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_comparator_if #(.WIDTH(W_A), .SLICE(S_A)) bus_a ();
  iter_comparator_if #(.WIDTH(W_B), .SLICE(S_B)) bus_b ();

  iter_comparator #(.WIDTH(W_A), .SLICE(S_A)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  iter_comparator #(.WIDTH(W_B), .SLICE(S_B)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    int   slices;
    int   cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic last_lt = 1'b0, last_eq = 1'b0, last_gt = 1'b0;
  int   last_sl = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input int s, input logic [31:0] a,
                                 input logic [31:0] b, input logic sg);
    exp_t        e;
    longint      av;
    longint      bv;
    logic [31:0] d;
    logic        found;
    av = longint'(a);
    bv = longint'(b);
    if (sg && a[w-1]) av = av - (longint'(1) << w);
    if (sg && b[w-1]) bv = bv - (longint'(1) << w);
    e.lt = (av < bv);
    e.eq = (av == bv);
    e.gt = (av > bv);
    d = a ^ b;
    e.slices = w / s;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        found    = 1'b1;
        e.slices = (w - 1 - i) / s + 1;
      end
    end
    e.cyc = 0;
    return e;
  endfunction

  // Monitor for the 32-bit instance
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      if (pv_a) chk("ready_after_valid_a", bus_a.o_ready, 1);
      if (bus_a.o_valid) begin
        chk("ready_low_in_done_a", bus_a.o_ready, 0);
        chk("onehot_a", int'(bus_a.o_lt) + int'(bus_a.o_eq) + int'(bus_a.o_gt), 1);
        if (q_a.size() == 0) begin
          chk("spurious_valid_a", bus_a.o_valid, 0);
        end else begin
          e = q_a.pop_front();
          chk("lt_a", bus_a.o_lt, e.lt);
          chk("eq_a", bus_a.o_eq, e.eq);
          chk("gt_a", bus_a.o_gt, e.gt);
          chk("slices_a", bus_a.o_slices, e.slices);
          chk("latency_a", cyc, e.cyc);
          last_lt = e.lt; last_eq = e.eq; last_gt = e.gt; last_sl = e.slices;
        end
      end
      pv_a = bus_a.o_valid;
    end else begin
      pv_a = 1'b0;
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n) begin
      if (pv_b) chk("ready_after_valid_b", bus_b.o_ready, 1);
      if (bus_b.o_valid) begin
        chk("ready_low_in_done_b", bus_b.o_ready, 0);
        if (q_b.size() == 0) begin
          chk("spurious_valid_b", bus_b.o_valid, 0);
        end else begin
          e = q_b.pop_front();
          chk("lt_b", bus_b.o_lt, e.lt);
          chk("eq_b", bus_b.o_eq, e.eq);
          chk("gt_b", bus_b.o_gt, e.gt);
          chk("slices_b", bus_b.o_slices, e.slices);
          chk("latency_b", cyc, e.cyc);
        end
      end
      pv_b = bus_b.o_valid;
    end else begin
      pv_b = 1'b0;
    end
  end

  task automatic start_a(input logic [31:0] a, input logic [31:0] b, input logic sg);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (bus_a.o_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait_a", bus_a.o_ready, 1);
    bus_a.i_start  = 1'b1;
    bus_a.i_rs1    = a;
    bus_a.i_rs2    = b;
    bus_a.i_signed = sg;
    e = model(W_A, S_A, a, b, sg);
    @(posedge clk);
    #1;
    bus_a.i_start = 1'b0;
    e.cyc = cyc + e.slices;
    q_a.push_back(e);
  endtask

  task automatic start_b(input logic [7:0] a, input logic [7:0] b, input logic sg);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (bus_b.o_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait_b", bus_b.o_ready, 1);
    bus_b.i_start  = 1'b1;
    bus_b.i_rs1    = a;
    bus_b.i_rs2    = b;
    bus_b.i_signed = sg;
    e = model(W_B, S_B, {24'h0, a}, {24'h0, b}, sg);
    @(posedge clk);
    #1;
    bus_b.i_start = 1'b0;
    e.cyc = cyc + e.slices;
    q_b.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || bus_a.o_ready !== 1'b1 ||
            bus_b.o_ready !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] b;
    bus_a.i_start = 1'b0; bus_a.i_signed = 1'b0; bus_a.i_abort = 1'b0;
    bus_a.i_rs1 = '0; bus_a.i_rs2 = '0;
    bus_b.i_start = 1'b0; bus_b.i_signed = 1'b0; bus_b.i_abort = 1'b0;
    bus_b.i_rs1 = '0; bus_b.i_rs2 = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus_a.o_valid, 0);
    chk("rst_lt", bus_a.o_lt, 0);
    chk("rst_eq", bus_a.o_eq, 0);
    chk("rst_gt", bus_a.o_gt, 0);
    chk("rst_slices", bus_a.o_slices, 0);
    chk("rst_ready", bus_a.o_ready, 1);
    chk("rst_ready_b", bus_b.o_ready, 1);
    rst_n = 1'b1;

    start_a(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    drain();
    start_a(32'h1234_5678, 32'h1234_5678, 1'b0);
    drain();
    start_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    start_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    drain();

    // Start pulsed mid-run must be ignored
    start_a(32'h0000_0002, 32'h0000_0003, 1'b0);
    repeat (3) @(negedge clk);
    bus_a.i_start = 1'b1; bus_a.i_rs1 = 32'hFFFF_FFFF; bus_a.i_rs2 = 32'h0;
    @(negedge clk);
    bus_a.i_start = 1'b0;
    drain();

    // Abort an equal-operand compare; flags must hold the previous result
    start_a(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
    repeat (4) @(negedge clk);
    bus_a.i_abort = 1'b1;
    @(posedge clk);
    #1;
    bus_a.i_abort = 1'b0;
    q_a.delete(q_a.size() - 1);
    @(negedge clk);
    chk("abort_ready", bus_a.o_ready, 1);
    chk("abort_valid", bus_a.o_valid, 0);
    chk("abort_lt", bus_a.o_lt, last_lt);
    chk("abort_eq", bus_a.o_eq, last_eq);
    chk("abort_gt", bus_a.o_gt, last_gt);
    chk("abort_slices", bus_a.o_slices, last_sl);
    repeat (20) @(negedge clk);

    // Reset mid-run
    start_a(32'h5A5A_0F0F, 32'h5A5A_0F0F, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q_a.delete(q_a.size() - 1);
    @(negedge clk);
    chk("mrst_valid", bus_a.o_valid, 0);
    chk("mrst_lt", bus_a.o_lt, 0);
    chk("mrst_eq", bus_a.o_eq, 0);
    chk("mrst_gt", bus_a.o_gt, 0);
    chk("mrst_slices", bus_a.o_slices, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_ready", bus_a.o_ready, 1);
    chk("mrst_valid_after", bus_a.o_valid, 0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0:       b = $urandom;
        1:       b = a;
        default: b = a ^ (32'h1 << $urandom_range(0, 31));
      endcase
      start_a(a, b, 1'($urandom_range(0, 1)));
    end
    drain();

    start_b(8'h80, 8'h7F, 1'b1);
    start_b(8'h5A, 8'h5A, 1'b1);
    start_b(8'h80, 8'h7F, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      start_b(a[7:0], b[7:0], 1'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
